core_fetcher: RTL and testbench

- Instruction fetch stage directly upstream of the per-core controller.
- When the controller enters FETCH, the block returns the 16-bit instruction at current_pc and reports progress on fetcher_state; the controller advances to DECODE on FETCHED.
- Contains a small direct-mapped instruction buffer, so tight loops avoid program-memory round trips.
- Talks to the shared program-memory controller through a valid/ready read channel.

---
 rtl/core_fetcher_pkg.sv | 27 ++
 rtl/fetch_icache.sv | 70 +++++++
 rtl/core_fetcher.sv | 115 +++++++++++
 tb/tb_core_fetcher.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_fetcher_pkg.sv
// Shared encodings and default widths for the core controller and its fetch stage.
// The controller and core_fetcher both import these, so the state values have one source.
package core_fetcher_pkg;

    localparam int DEFAULT_ADDR_BITS   = 8;
    localparam int DEFAULT_DATA_BITS   = 16;
    localparam int DEFAULT_CACHE_LINES = 4;
    localparam int DEFAULT_COUNT_BITS  = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_e;

endpackage

// File: rtl/fetch_icache.sv
// Direct-mapped instruction buffer: valid/tag/data arrays, combinational hit lookup,
// a single fill port and a whole-buffer invalidate that takes priority over a fill.
module fetch_icache
    import core_fetcher_pkg::*;
#(
    parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int CACHE_LINES = DEFAULT_CACHE_LINES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] i_lookup_addr,
    output logic                 o_hit,
    output logic [DATA_BITS-1:0] o_hit_data,
    input  logic                 i_fill_en,
    input  logic [ADDR_BITS-1:0] i_fill_addr,
    input  logic [DATA_BITS-1:0] i_fill_data,
    input  logic                 i_invalidate
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [CACHE_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]    r_tag  [CACHE_LINES];
    logic [DATA_BITS-1:0]   r_data [CACHE_LINES];

    logic [IDX_BITS-1:0] w_lookup_idx;
    logic [TAG_BITS-1:0] w_lookup_tag;
    logic [IDX_BITS-1:0] w_fill_idx;
    logic [TAG_BITS-1:0] w_fill_tag;

    assign w_lookup_idx = i_lookup_addr[IDX_BITS-1:0];
    assign w_lookup_tag = i_lookup_addr[ADDR_BITS-1:IDX_BITS];
    assign w_fill_idx   = i_fill_addr[IDX_BITS-1:0];
    assign w_fill_tag   = i_fill_addr[ADDR_BITS-1:IDX_BITS];

    // Lookup always sees the contents before this edge, even when invalidate is pulsing.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = r_data[w_lookup_idx];
        if (r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag)) begin
            o_hit = 1'b1;
        end else begin
            o_hit = 1'b0;
        end
    end

    // Valid bits: invalidate beats a coincident fill, leaving the filled line unusable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_invalidate) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[w_fill_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and data arrays carry no reset; they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= i_fill_data;
        end
    end

endmodule

// File: rtl/core_fetcher.sv
// Instruction fetch stage: serves FETCH requests from the local buffer or, on a miss,
// through a single outstanding valid/ready read to program memory. All outputs are registered.
module core_fetcher
    import core_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
    parameter int CACHE_LINES           = DEFAULT_CACHE_LINES,
    parameter int COUNT_BITS            = DEFAULT_COUNT_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNT_BITS-1:0]            hit_count,
    output logic [COUNT_BITS-1:0]            miss_count
);

    localparam logic [COUNT_BITS-1:0] COUNT_MAX = {COUNT_BITS{1'b1}};
    localparam logic [COUNT_BITS-1:0] COUNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

    fetcher_state_e                   r_state;
    logic                             r_mem_read_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_read_address;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;
    logic [COUNT_BITS-1:0]            r_hit_count;
    logic [COUNT_BITS-1:0]            r_miss_count;

    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;
    logic                             w_fill_en;

    // The request address is held for the whole miss, so it doubles as the fill address.
    assign w_fill_en = (r_state == FETCHER_FETCHING) && mem_read_ready;

    fetch_icache #(
        .ADDR_BITS   (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS   (PROGRAM_MEM_DATA_BITS),
        .CACHE_LINES (CACHE_LINES)
    ) u_icache (
        .clk           (clk),
        .reset         (reset),
        .i_lookup_addr (current_pc),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data),
        .i_fill_en     (w_fill_en),
        .i_fill_addr   (r_mem_read_address),
        .i_fill_data   (mem_read_data),
        .i_invalidate  (cache_invalidate)
    );

    // Fetch FSM with memory handshake and saturating hit/miss counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= FETCHER_IDLE;
            r_mem_read_valid   <= 1'b0;
            r_mem_read_address <= '0;
            r_instruction      <= '0;
            r_hit_count        <= '0;
            r_miss_count       <= '0;
        end else begin
            case (r_state)
                FETCHER_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (w_hit) begin
                            r_instruction <= w_hit_data;
                            r_state       <= FETCHER_FETCHED;
                            if (r_hit_count != COUNT_MAX) begin
                                r_hit_count <= r_hit_count + COUNT_ONE;
                            end
                        end else begin
                            r_mem_read_valid   <= 1'b1;
                            r_mem_read_address <= current_pc;
                            r_state            <= FETCHER_FETCHING;
                            if (r_miss_count != COUNT_MAX) begin
                                r_miss_count <= r_miss_count + COUNT_ONE;
                            end
                        end
                    end
                end
                FETCHER_FETCHING: begin
                    if (mem_read_ready) begin
                        r_instruction    <= mem_read_data;
                        r_mem_read_valid <= 1'b0;
                        r_state          <= FETCHER_FETCHED;
                    end
                end
                FETCHER_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        r_state <= FETCHER_IDLE;
                    end
                end
                default: begin
                    r_state          <= FETCHER_IDLE;
                    r_mem_read_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fetcher_state    = r_state;
    assign mem_read_valid   = r_mem_read_valid;
    assign mem_read_address = r_mem_read_address;
    assign instruction      = r_instruction;
    assign hit_count        = r_hit_count;
    assign miss_count       = r_miss_count;

endmodule

// File: tb/tb_core_fetcher.sv
// Randomized self-checking bench for core_fetcher against a line-ownership model of the buffer.
// A second, narrow-counter instance shares the stimulus so counter saturation is reachable quickly.
module tb_core_fetcher;
    import core_fetcher_pkg::*;

    localparam int LINES    = 4;
    localparam int SAT_BITS = 4;
    localparam int SAT_MAX  = (1 << SAT_BITS) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        cache_invalidate;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;

    logic        mem_read_valid, s_mem_read_valid;
    logic [7:0]  mem_read_address, s_mem_read_address;
    logic [2:0]  fetcher_state, s_fetcher_state;
    logic [15:0] instruction, s_instruction;
    logic [15:0] hit_count, miss_count;
    logic [SAT_BITS-1:0] s_hit_count, s_miss_count;

    int checks = 0;
    int failures = 0;

    logic [15:0] prog [256];
    int          line_pc [LINES];
    int          n_hits, n_misses;
    logic [15:0] exp_instr;

    core_fetcher dut (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
        .cache_invalidate(cache_invalidate), .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
        .instruction(instruction), .hit_count(hit_count), .miss_count(miss_count)
    );

    core_fetcher #(.COUNT_BITS(SAT_BITS)) dut_sat (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
        .cache_invalidate(cache_invalidate), .mem_read_valid(s_mem_read_valid),
        .mem_read_address(s_mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .fetcher_state(s_fetcher_state),
        .instruction(s_instruction), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st, input logic vld,
                                 input logic [7:0] addr, input logic chk_ins);
        check({tag, ".state"}, {29'd0, fetcher_state}, {29'd0, st});
        check({tag, ".sat_state"}, {29'd0, s_fetcher_state}, {29'd0, st});
        check({tag, ".valid"}, {31'd0, mem_read_valid}, {31'd0, vld});
        check({tag, ".sat_valid"}, {31'd0, s_mem_read_valid}, {31'd0, vld});
        if (vld) begin
            check({tag, ".addr"}, {24'd0, mem_read_address}, {24'd0, addr});
            check({tag, ".sat_addr"}, {24'd0, s_mem_read_address}, {24'd0, addr});
        end
        if (chk_ins) begin
            check({tag, ".instr"}, {16'd0, instruction}, {16'd0, exp_instr});
            check({tag, ".sat_instr"}, {16'd0, s_instruction}, {16'd0, exp_instr});
        end
    endtask

    task automatic check_counters(input string tag);
        int eh, em;
        eh = (n_hits > 65535) ? 65535 : n_hits;
        em = (n_misses > 65535) ? 65535 : n_misses;
        check({tag, ".hits"}, {16'd0, hit_count}, eh);
        check({tag, ".misses"}, {16'd0, miss_count}, em);
        eh = (n_hits > SAT_MAX) ? SAT_MAX : n_hits;
        em = (n_misses > SAT_MAX) ? SAT_MAX : n_misses;
        check({tag, ".sat_hits"}, {28'd0, s_hit_count}, eh);
        check({tag, ".sat_misses"}, {28'd0, s_miss_count}, em);
    endtask

    task automatic clear_lines();
        for (int i = 0; i < LINES; i++) line_pc[i] = -1;
    endtask

    // Entered at a falling edge with the DUT idle; returns at a falling edge, DUT idle again.
    task automatic do_fetch(input logic [7:0] pc, input int delay, input logic inv_lookup,
                            input logic inv_fill, input logic inv_hold);
        logic       hit_e;
        logic [2:0] v;
        hit_e = (line_pc[int'(pc) % LINES] == int'(pc));
        core_state = CORE_FETCH;
        current_pc = pc;
        cache_invalidate = inv_lookup;
        @(negedge clk);
        cache_invalidate = 1'b0;
        if (inv_lookup) clear_lines();
        if (hit_e) begin
            n_hits++;
            exp_instr = prog[pc];
            check_outputs("hit", FETCHER_FETCHED, 1'b0, pc, 1'b1);
        end else begin
            n_misses++;
            check_outputs("req", FETCHER_FETCHING, 1'b1, pc, 1'b0);
            for (int k = 1; k < delay; k++) begin
                core_state = 3'($urandom_range(0, 7));
                @(negedge clk);
                check_outputs("wait", FETCHER_FETCHING, 1'b1, pc, 1'b0);
            end
            mem_read_ready = 1'b1;
            mem_read_data = prog[pc];
            cache_invalidate = inv_fill;
            @(negedge clk);
            mem_read_ready = 1'b0;
            mem_read_data = 16'($urandom);
            cache_invalidate = 1'b0;
            exp_instr = prog[pc];
            if (inv_fill) clear_lines();
            else line_pc[int'(pc) % LINES] = int'(pc);
            check_outputs("fill", FETCHER_FETCHED, 1'b0, pc, 1'b1);
        end
        check_counters("cnt");
        v = 3'($urandom_range(0, 7));
        if (v == CORE_DECODE) v = CORE_EXECUTE;
        core_state = v;
        cache_invalidate = inv_hold;
        @(negedge clk);
        cache_invalidate = 1'b0;
        if (inv_hold) clear_lines();
        check_outputs("hold", FETCHER_FETCHED, 1'b0, pc, 1'b1);
        core_state = CORE_DECODE;
        @(negedge clk);
        check_outputs("decode", FETCHER_IDLE, 1'b0, pc, 1'b0);
        core_state = CORE_IDLE;
    endtask

    initial begin
        reset = 1'b1;
        core_state = CORE_IDLE;
        current_pc = 8'h00;
        cache_invalidate = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data = 16'h0000;
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        prog[5] = 16'hA1B2;
        clear_lines();
        n_hits = 0;
        n_misses = 0;
        exp_instr = 16'h0000;

        @(negedge clk);
        @(negedge clk);
        check_outputs("reset", FETCHER_IDLE, 1'b0, 8'h00, 1'b1);
        check("reset.addr", {24'd0, mem_read_address}, 32'd0);
        check_counters("reset");
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, then hit on the same PC.
        do_fetch(8'h05, 3, 1'b0, 1'b0, 1'b0);
        check("cold.misses", {16'd0, miss_count}, 32'd1);
        do_fetch(8'h05, 1, 1'b0, 1'b0, 1'b0);
        check("hit.hits", {16'd0, hit_count}, 32'd1);

        // Conflict on line 1, then the line must own 8'h01.
        do_fetch(8'h01, 2, 1'b0, 1'b0, 1'b0);
        do_fetch(8'h05, 1, 1'b0, 1'b0, 1'b0);
        do_fetch(8'h01, 2, 1'b0, 1'b0, 1'b0);
        check("conflict.misses", {16'd0, miss_count}, 32'd4);
        do_fetch(8'h01, 1, 1'b0, 1'b0, 1'b0);
        check("conflict.owner", {16'd0, hit_count}, 32'd2);

        // Invalidate coincident with a fill: delivered, but refetch misses.
        do_fetch(8'h02, 2, 1'b0, 1'b1, 1'b0);
        do_fetch(8'h02, 1, 1'b0, 1'b0, 1'b0);
        check("inv_fill.misses", {16'd0, miss_count}, 32'd6);

        // Invalidate during a hit lookup still hits, then the next lookup misses.
        do_fetch(8'h02, 1, 1'b1, 1'b0, 1'b0);
        check("inv_lookup.hits", {16'd0, hit_count}, 32'd3);
        do_fetch(8'h02, 1, 1'b0, 1'b0, 1'b0);
        check("inv_lookup.misses", {16'd0, miss_count}, 32'd7);

        for (int n = 0; n < 80; n++) begin
            do_fetch(8'($urandom_range(0, 11)), int'($urandom_range(1, 4)),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) == 0));
        end

        for (int n = 0; n < 20; n++) do_fetch(8'h03, 1, 1'b0, 1'b0, 1'b0);
        check("sat.hit_count", {28'd0, s_hit_count}, SAT_MAX);
        check("sat.miss_count", {28'd0, s_miss_count}, SAT_MAX);

        // Reset in the middle of a miss drops the request at once.
        core_state = CORE_FETCH;
        current_pc = 8'h10;
        @(negedge clk);
        check_outputs("rst_req", FETCHER_FETCHING, 1'b1, 8'h10, 1'b0);
        #2 reset = 1'b1;
        #1;
        clear_lines();
        n_hits = 0;
        n_misses = 0;
        exp_instr = 16'h0000;
        check_outputs("rst_async", FETCHER_IDLE, 1'b0, 8'h10, 1'b1);
        check_counters("rst_async");
        @(negedge clk);
        reset = 1'b0;
        core_state = CORE_IDLE;
        mem_read_ready = 1'b1;
        mem_read_data = 16'hDEAD;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check_outputs("late_ready", FETCHER_IDLE, 1'b0, 8'h10, 1'b1);
        check_counters("late_ready");
        do_fetch(8'h10, 2, 1'b0, 1'b0, 1'b0);
        check("post_rst.misses", {16'd0, miss_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
